ula_op_sequencer: RTL

Command sequencer that drives the combinational ULA from a buffered stream of operation requests and returns each result through a valid/ready handshake. It registers the operands and opcode presented to the ULA, captures Out/Carry_out/Zero one cycle later, and can chain operations by substituting the previous result for operand A. It sits between a command source (test controller or future datapath FSM) and the ULA instance.

---
 rtl/ula_op_sequencer_if.sv | 35 +++
 rtl/ula_op_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ula_op_sequencer_if.sv
// Command and result channels between a command source/result consumer and
// the ULA operation sequencer.
interface ula_op_sequencer_if #(
    parameter int WIDTH = 6
);
    // Both channels transfer on a rising edge where valid && ready. The sender
    // holds valid and payload stable until that edge, and valid never waits on ready.
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_set;
    logic [2:0]       cmd_setop;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_out;
    logic             res_carry;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_set, cmd_setop, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  res_valid, res_out, res_carry, res_zero,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_set, cmd_setop, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output res_valid, res_out, res_carry, res_zero,
        input  res_ready
    );
endinterface

// File: rtl/ula_op_sequencer.sv
// Buffers ULA operation requests, drives registered operands into the ULA,
// captures its result one cycle later and returns it over a valid/ready channel.
module ula_op_sequencer #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    ula_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_set,
    output logic [2:0]        alu_setop,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic [7:0]        op_count,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic             set;
        logic [2:0]       setop;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             use_acc;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_set_q, alu_set_d;
    logic [2:0]       alu_setop_q, alu_setop_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_out_q, res_out_d;
    logic             res_carry_q, res_carry_d;
    logic             res_zero_q, res_zero_d;
    logic [7:0]       op_count_q, op_count_d;

    logic push;
    logic pop;
    cmd_t head;
    cmd_t incoming;

    // Ready comes only from the registered count, so a same-cycle pop never
    // opens a slot for a same-cycle push; it is also forced low during reset.
    assign bus.cmd_ready = Reset && (count_q != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state_q == S_IDLE) && (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign incoming      = '{set:     bus.cmd_set,
                             setop:   bus.cmd_setop,
                             a:       bus.cmd_a,
                             b:       bus.cmd_b,
                             use_acc: bus.cmd_use_acc};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = incoming;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_set_d   = alu_set_q;
        alu_setop_d = alu_setop_q;
        res_valid_d = res_valid_q;
        res_out_d   = res_out_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        op_count_d  = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    alu_a_d     = head.use_acc ? acc_q : head.a;
                    alu_b_d     = head.b;
                    alu_set_d   = head.set;
                    alu_setop_d = head.setop;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                // The ULA has settled on the operands registered last cycle.
                res_out_d   = alu_out;
                res_carry_d = alu_carry;
                res_zero_d  = alu_zero;
                acc_d       = alu_out;
                res_valid_d = 1'b1;
                op_count_d  = op_count_q + 8'd1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_set_q   <= 1'b0;
            alu_setop_q <= '0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_set_q   <= alu_set_d;
            alu_setop_q <= alu_setop_d;
            res_valid_q <= res_valid_d;
            res_out_q   <= res_out_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_set       = alu_set_q;
    assign alu_setop     = alu_setop_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_out   = res_out_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = res_zero_q;
    assign op_count      = op_count_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);
    assign dbg_state     = state_q;
endmodule
